// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game-state engine: cursor movement, X/O placement, sequential 8-line win scan, draw detection.
// Optional feature macro TTT_AUTO_RESTART_EN: when defined, WIN/DRAW restart automatically after RESTART_CYCLES clocks.
module tictactoe_game_ctrl #(
    parameter logic [1:0]  START_SYM      = 2'b01,
    parameter logic [25:0] RESTART_CYCLES = 26'd50_000_000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iBtnUp,
    input  logic        iBtnDown,
    input  logic        iBtnLeft,
    input  logic        iBtnRight,
    input  logic        iBtnSelect,
    input  logic        iBtnRestart,
    output logic [3:0]  oMarkedBlockPosX,
    output logic [3:0]  oMarkedBlockPosY,
    output logic [0:17] oSymVector,
    output logic [14:0] oWinSeqPos,
    output logic        oWinFlag,
    output logic        oDrawFlag,
    output logic [1:0]  oCurrentSym
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WIN   = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_X     = 2'b01;
    localparam logic [1:0] SYM_O     = 2'b10;

    // Cells of winning line l packed as {c2, c1, c0}, ascending cell index.
    function automatic logic [11:0] line_cells(input logic [2:0] l);
        logic [11:0] r;
        case (l)
            3'd0:    r = {4'd2, 4'd1, 4'd0};
            3'd1:    r = {4'd5, 4'd4, 4'd3};
            3'd2:    r = {4'd8, 4'd7, 4'd6};
            3'd3:    r = {4'd6, 4'd3, 4'd0};
            3'd4:    r = {4'd7, 4'd4, 4'd1};
            3'd5:    r = {4'd8, 4'd5, 4'd2};
            3'd6:    r = {4'd8, 4'd4, 4'd0};
            default: r = {4'd6, 4'd4, 4'd2};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] cell_at(input logic [0:17] b, input logic [3:0] k);
        return b[{k, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] wrap_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  btn_q, btn_d;
    logic [1:0]  cur_x_q, cur_x_d;
    logic [1:0]  cur_y_q, cur_y_d;
    logic [0:17] board_q, board_d;
    logic [14:0] win_seq_q, win_seq_d;
    logic [1:0]  cur_sym_q, cur_sym_d;
    logic [3:0]  move_cnt_q, move_cnt_d;
    logic [2:0]  line_q, line_d;

    logic [5:0]  btn_in_s;
    logic [5:0]  edge_s;
    logic        auto_restart_s;
    logic [3:0]  cur_cell_s;
    logic [11:0] cells_s;
    logic        line_match_s;
    logic        win_flag_s;
    logic        draw_flag_s;

    // Button bit order: [5] restart, [4] select, [3] up, [2] down, [1] left, [0] right.
    assign btn_in_s   = {iBtnRestart, iBtnSelect, iBtnUp, iBtnDown, iBtnLeft, iBtnRight};
    assign edge_s     = btn_in_s & ~btn_q;
    assign cur_cell_s = {2'b00, cur_x_q} + 4'd3 * {2'b00, cur_y_q};
    assign cells_s    = line_cells(line_q);
    assign line_match_s = (cell_at(board_q, cells_s[3:0])  == cur_sym_q) &&
                          (cell_at(board_q, cells_s[7:4])  == cur_sym_q) &&
                          (cell_at(board_q, cells_s[11:8]) == cur_sym_q);

`ifdef TTT_AUTO_RESTART_EN
    logic [25:0] ar_cnt_q, ar_cnt_d;

    // Auto-restart counter: zero outside WIN/DRAW, so it starts from zero on entry.
    always_comb begin
        ar_cnt_d = 26'd0;
        if ((state_q == ST_WIN) || (state_q == ST_DRAW)) begin
            ar_cnt_d = ar_cnt_q + 26'd1;
        end else begin
            ar_cnt_d = 26'd0;
        end
    end

    // Auto-restart counter register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ar_cnt_q <= 26'd0;
        end else begin
            ar_cnt_q <= ar_cnt_d;
        end
    end

    assign auto_restart_s = ((state_q == ST_WIN) || (state_q == ST_DRAW)) &&
                            (ar_cnt_q == RESTART_CYCLES - 26'd1);
`else
    assign auto_restart_s = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_PLAY;
            btn_q      <= 6'd0;
            cur_x_q    <= 2'd0;
            cur_y_q    <= 2'd0;
            board_q    <= 18'd0;
            win_seq_q  <= 15'd0;
            cur_sym_q  <= START_SYM;
            move_cnt_q <= 4'd0;
            line_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            board_q    <= board_d;
            win_seq_q  <= win_seq_d;
            cur_sym_q  <= cur_sym_d;
            move_cnt_q <= move_cnt_d;
            line_q     <= line_d;
        end
    end

    // Next-state logic: one action per clock, restart overrides everything.
    always_comb begin
        state_d    = state_q;
        btn_d      = btn_in_s;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        board_d    = board_q;
        win_seq_d  = win_seq_q;
        cur_sym_d  = cur_sym_q;
        move_cnt_d = move_cnt_q;
        line_d     = line_q;

        if (edge_s[5] || auto_restart_s) begin
            state_d    = ST_PLAY;
            cur_x_d    = 2'd0;
            cur_y_d    = 2'd0;
            board_d    = 18'd0;
            win_seq_d  = 15'd0;
            cur_sym_d  = START_SYM;
            move_cnt_d = 4'd0;
            line_d     = 3'd0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (edge_s[4]) begin
                        if (cell_at(board_q, cur_cell_s) == SYM_EMPTY) begin
                            board_d[{cur_cell_s, 1'b0} +: 2] = cur_sym_q;
                            move_cnt_d = move_cnt_q + 4'd1;
                            line_d     = 3'd0;
                            state_d    = ST_CHECK;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else if (edge_s[3]) begin
                        cur_y_d = wrap_dec(cur_y_q);
                    end else if (edge_s[2]) begin
                        cur_y_d = wrap_inc(cur_y_q);
                    end else if (edge_s[1]) begin
                        cur_x_d = wrap_dec(cur_x_q);
                    end else if (edge_s[0]) begin
                        cur_x_d = wrap_inc(cur_x_q);
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_CHECK: begin
                    if (line_match_s) begin
                        state_d   = ST_WIN;
                        win_seq_d = {cells_s[11:8], 1'b0, cells_s[7:4], 1'b0, cells_s[3:0], 1'b0};
                    end else if (line_q == 3'd7) begin
                        if (move_cnt_q == 4'd9) begin
                            state_d = ST_DRAW;
                        end else begin
                            cur_sym_d = (cur_sym_q == SYM_X) ? SYM_O : SYM_X;
                            state_d   = ST_PLAY;
                        end
                    end else begin
                        line_d = line_q + 3'd1;
                    end
                end
                ST_WIN:  state_d = ST_WIN;
                ST_DRAW: state_d = ST_DRAW;
                default: state_d = ST_PLAY;
            endcase
        end
    end

    // Status flags decoded from the registered state.
    always_comb begin
        win_flag_s  = 1'b0;
        draw_flag_s = 1'b0;
        case (state_q)
            ST_WIN:  win_flag_s  = 1'b1;
            ST_DRAW: draw_flag_s = 1'b1;
            default: begin
                win_flag_s  = 1'b0;
                draw_flag_s = 1'b0;
            end
        endcase
    end

    assign oMarkedBlockPosX = {2'b00, cur_x_q};
    assign oMarkedBlockPosY = {2'b00, cur_y_q};
    assign oSymVector       = board_q;
    assign oWinSeqPos       = win_seq_q;
    assign oWinFlag         = win_flag_s;
    assign oDrawFlag        = draw_flag_s;
    assign oCurrentSym      = cur_sym_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Scoreboard bench for tictactoe_game_ctrl: driver queues expected snapshots, monitor compares on the falling edge.
module tb_tictactoe_game_ctrl;

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam int B_RST = 5, B_SEL = 4, B_UP = 3, B_DN = 2, B_LT = 1, B_RT = 0;

    typedef struct packed {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [17:0] board;
        logic [14:0] ws;
        logic        win;
        logic        draw;
        logic [1:0]  sym;
    } snap_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  btn = 6'd0;
    logic [3:0]  oMarkedBlockPosX, oMarkedBlockPosY;
    logic [0:17] oSymVector;
    logic [14:0] oWinSeqPos;
    logic        oWinFlag, oDrawFlag;
    logic [1:0]  oCurrentSym;

    snap_t exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    tx = 0;
    int    ty = 0;

    tictactoe_game_ctrl dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .iBtnUp           (btn[B_UP]),
        .iBtnDown         (btn[B_DN]),
        .iBtnLeft         (btn[B_LT]),
        .iBtnRight        (btn[B_RT]),
        .iBtnSelect       (btn[B_SEL]),
        .iBtnRestart      (btn[B_RST]),
        .oMarkedBlockPosX (oMarkedBlockPosX),
        .oMarkedBlockPosY (oMarkedBlockPosY),
        .oSymVector       (oSymVector),
        .oWinSeqPos       (oWinSeqPos),
        .oWinFlag         (oWinFlag),
        .oDrawFlag        (oDrawFlag),
        .oCurrentSym      (oCurrentSym)
    );

    always #5 Clock = ~Clock;

    function automatic logic [17:0] mk(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        return {c0, c1, c2, c3, c4, c5, c6, c7, c8};
    endfunction

    task automatic chk(input string nm, input int x, input int y, input logic [17:0] board,
                       input logic [14:0] ws, input logic win, input logic draw, input logic [1:0] sym);
        snap_t s;
        s.x = 4'(x); s.y = 4'(y); s.board = board; s.ws = ws;
        s.win = win; s.draw = draw; s.sym = sym;
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    task automatic press(input logic [5:0] mask);
        @(posedge Clock); #1;
        btn = mask;
        @(posedge Clock); #1;
        btn = 6'd0;
    endtask

    task automatic goto(input int k);
        while (tx != k % 3) begin
            press(6'b1 << B_RT);
            tx = (tx + 1) % 3;
        end
        while (ty != k / 3) begin
            press(6'b1 << B_DN);
            ty = (ty + 1) % 3;
        end
    endtask

    task automatic place(input int k);
        goto(k);
        press(6'b1 << B_SEL);
        repeat (8) @(posedge Clock);
        #1;
    endtask

    task automatic restart();
        press(6'b1 << B_RST);
        tx = 0;
        ty = 0;
    endtask

    // Monitor: compare every queued expectation against the outputs on the falling edge.
    initial begin
        snap_t e, a;
        string nm;
        forever begin
            @(negedge Clock);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.x = oMarkedBlockPosX; a.y = oMarkedBlockPosY; a.board = oSymVector;
                a.ws = oWinSeqPos; a.win = oWinFlag; a.draw = oDrawFlag; a.sym = oCurrentSym;
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got x=%0d y=%0d board=%h ws=%h win=%b draw=%b sym=%b, expected x=%0d y=%0d board=%h ws=%h win=%b draw=%b sym=%b",
                             nm, a.x, a.y, a.board, a.ws, a.win, a.draw, a.sym,
                             e.x, e.y, e.board, e.ws, e.win, e.draw, e.sym);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        chk("reset_state", 0, 0, 18'd0, 15'd0, 1'b0, 1'b0, X);

        // Cursor wrap and priority
        press(6'b1 << B_LT);
        chk("left_wrap", 2, 0, 18'd0, 15'd0, 1'b0, 1'b0, X);
        press(6'b1 << B_UP);
        chk("up_wrap", 2, 2, 18'd0, 15'd0, 1'b0, 1'b0, X);
        press((6'b1 << B_UP) | (6'b1 << B_RT));
        chk("up_over_right", 2, 1, 18'd0, 15'd0, 1'b0, 1'b0, X);
        restart();
        chk("restart_clear", 0, 0, 18'd0, 15'd0, 1'b0, 1'b0, X);

        // Row-0 win for X, found on line 0
        place(0); place(3); place(1); place(4);
        goto(2);
        press(6'b1 << B_SEL);
        chk("row_win_pre", 2, 0, mk(X, X, X, O, O, E, E, E, E), 15'd0, 1'b0, 1'b0, X);
        @(posedge Clock); #1;
        chk("row_win", 2, 0, mk(X, X, X, O, O, E, E, E, E), {5'd4, 5'd2, 5'd0}, 1'b1, 1'b0, X);
        press(6'b1 << B_DN);
        press(6'b1 << B_SEL);
        chk("win_hold", 2, 0, mk(X, X, X, O, O, E, E, E, E), {5'd4, 5'd2, 5'd0}, 1'b1, 1'b0, X);
        restart();
        chk("restart_after_win", 0, 0, 18'd0, 15'd0, 1'b0, 1'b0, X);

        // Anti-diagonal win, found on the last line
        place(2); place(0); place(4); place(1);
        goto(6);
        press(6'b1 << B_SEL);
        repeat (7) @(posedge Clock); #1;
        chk("anti_pre", 0, 2, mk(O, O, X, E, X, E, X, E, E), 15'd0, 1'b0, 1'b0, X);
        @(posedge Clock); #1;
        chk("anti_win", 0, 2, mk(O, O, X, E, X, E, X, E, E), {5'd12, 5'd8, 5'd4}, 1'b1, 1'b0, X);
        restart();

        // Draw, with an ignored select on an occupied cell
        place(0);
        press(6'b1 << B_SEL);
        repeat (10) @(posedge Clock); #1;
        chk("occupied_ignored", 0, 0, mk(X, E, E, E, E, E, E, E, E), 15'd0, 1'b0, 1'b0, O);
        place(1); place(2); place(4); place(3); place(5); place(7); place(6); place(8);
        chk("draw", 2, 2, mk(X, O, X, X, O, O, O, X, X), 15'd0, 1'b0, 1'b1, X);
        restart();

        // Restart while the line scan is running
        goto(4);
        press(6'b1 << B_SEL);
        restart();
        chk("restart_mid_check", 0, 0, 18'd0, 15'd0, 1'b0, 1'b0, X);
        repeat (10) @(posedge Clock); #1;
        chk("restart_mid_check_hold", 0, 0, 18'd0, 15'd0, 1'b0, 1'b0, X);

        // Asynchronous reset mid-game after O's turn begins
        place(4);
        place(0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        chk("async_reset", 0, 0, 18'd0, 15'd0, 1'b0, 1'b0, X);
        @(posedge Clock); #1;
        Reset = 1'b0;
        tx = 0;
        ty = 0;

        repeat (3) @(posedge Clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tictactoe_game_ctrl.md
Name: tictactoe_game_ctrl

Overview:
Game-state engine that produces the board, cursor and win information consumed by the VGA tic-tac-toe display block. It takes debounced button levels, moves a cursor over the 3x3 board and places alternating X/O symbols. After each placement it scans the 8 winning lines sequentially and drives the win, draw and winning-sequence outputs. Runs on the system clock; the display samples its outputs as quasi-static levels.

Parameters:
START_SYM, 2'b01, symbol of the first player after reset or restart (2'b01 = X, 2'b10 = O).
RESTART_CYCLES, 26'd50_000_000, auto-restart delay in clocks; used only with the optional feature.

Ports:
Clock  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
iBtnUp  in  1  debounced level; rising edge moves cursor Y-1.
iBtnDown  in  1  debounced level; rising edge moves cursor Y+1.
iBtnLeft  in  1  debounced level; rising edge moves cursor X-1.
iBtnRight  in  1  debounced level; rising edge moves cursor X+1.
iBtnSelect  in  1  debounced level; rising edge places a symbol at the cursor.
iBtnRestart  in  1  debounced level; rising edge clears the game.
oMarkedBlockPosX  out  4  cursor column, 0..2.
oMarkedBlockPosY  out  4  cursor row, 0..2.
oSymVector  out  [0:17]  board contents; cell k = x+3*y occupies bits [2k +: 2]. Codes: 00 = EMPTY, 01 = X, 10 = O; 11 is never driven.
oWinSeqPos  out  15  three 5-bit slots [0+:5], [5+:5], [10+:5], each holding 2*k of a winning cell, in ascending k.
oWinFlag  out  1  high while in WIN.
oDrawFlag  out  1  high while in DRAW.
oCurrentSym  out  2  symbol to be placed next.

Behaviour:
- Reset (asynchronous): cursor (0,0); oSymVector all 0; oWinSeqPos 0; oWinFlag 0; oDrawFlag 0; oCurrentSym = START_SYM; move count 0; button edge registers 0; state PLAY.
- Edge detection: each button is registered once. An edge is rBtn_q == 0 && iBtn == 1. At most one action is taken per clock. Priority: Restart > Select > Up > Down > Left > Right. Lower-priority edges in the same cycle are dropped.
- PLAY:
  - Direction edges wrap modulo 3 (0-1 -> 2, 2+1 -> 0). Upper 2 bits of the position outputs are always 0.
  - Select on an EMPTY cell: write oCurrentSym into cell k at that edge, increment move count (4-bit), go to CHECK with line index L = 0.
  - Select on an occupied cell: ignored.
- CHECK: evaluates one line per clock, L = 0..7.
  - Line order: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonal {0,4,8}; anti-diagonal {2,4,6}.
  - Match: all three cells equal the placed symbol. On match at L, next state is WIN and oWinSeqPos loads {2*c2, 2*c1, 2*c0}, with c0 in slot [0+:5].
  - No match and L = 7: if move count = 9, go to DRAW; otherwise toggle oCurrentSym (01 <-> 10) and return to PLAY.
  - Worst-case latency: Select edge to PLAY = 9 clocks.
  - All edges except Restart are dropped during CHECK.
- WIN / DRAW: board, cursor and oWinSeqPos hold. Only Restart is honoured.
- Restart edge in any state, including mid-CHECK: next clock returns to the reset values and state PLAY, except that the button edge registers keep sampling.
- Outputs are registered; no combinational path from input to output.

Optional Feature:
TTT_AUTO_RESTART_EN.
- Defined: a 26-bit counter clears on entry to WIN or DRAW and counts each clock. When it reaches RESTART_CYCLES-1, the block performs a restart on the next clock. A manual Restart still acts immediately.
- Not defined: the counter is not built and WIN/DRAW hold until Restart.

Test Plan:
- Reset asserted mid-game -> all outputs return to reset values immediately, without waiting for a clock edge; oCurrentSym = 01.
- Left edge at (0,0) -> (2,0); Up edge at (2,0) -> (2,2); Up and Right edges in the same cycle -> only Y changes.
- X at cells 0,1,2 with O at 3,4 -> oWinFlag = 1 exactly 1 clock after CHECK line 0; oWinSeqPos = {5'd4, 5'd2, 5'd0}. Further Select edges leave oSymVector unchanged.
- Anti-diagonal X win on cells 2,4,6 -> oWinFlag = 1 after 8 CHECK clocks; oWinSeqPos = {5'd12, 5'd8, 5'd4}.
- Full board with no line, X/O order 0,1,2,4,3,5,7,6,8 -> oDrawFlag = 1, oWinFlag = 0. Select on an occupied cell earlier in the sequence -> ignored, and oCurrentSym does not toggle.
- Restart edge during CHECK -> board clears and state is PLAY next clock. With TTT_AUTO_RESTART_EN defined and RESTART_CYCLES = 16, WIN clears itself 16 clocks after entry.
